// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: widths and access-type decode shared by the MEM stage.
// Store buffer option: MEM_STORE_BUF_EN (see mem_access_stage).
package mem_stage_pkg;

    localparam int MS_DATA_W = 16;
    localparam int MS_ADDR_W = 16;
    localparam int MS_IDX_W  = 4;
    localparam int MS_RD_W   = 3;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_LOAD,
        ACC_STORE
    } acc_t;

    // Load takes priority when both type bits are set.
    function automatic acc_t acc_decode(
        input logic ld,
        input logic st,
        input logic go
    );
        acc_t a;
        a = ACC_NONE;
        unique case (1'b1)
            go && ld:        a = ACC_LOAD;
            go && st && !ld: a = ACC_STORE;
            default:         a = ACC_NONE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: single shared data-memory port.
// master = MEM stage, slave = data memory.
interface mem_access_stage_if
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = MS_ADDR_W,
    parameter int DATA_W = MS_DATA_W
);
    logic              read_mem;
    logic              write_mem;
    logic [ADDR_W-1:0] rw_address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (
        output read_mem,
        output write_mem,
        output rw_address,
        output write_data,
        input  read_data
    );

    modport slave (
        input  read_mem,
        input  write_mem,
        input  rw_address,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/mem_store_buf.sv
// mem_store_buf: one-entry store buffer with index-match load forwarding.
// Drains whenever the port is not taken by an accepted load.
module mem_store_buf
    import mem_stage_pkg::*;
#(
    parameter int DATA_W    = MS_DATA_W,
    parameter int ADDR_W    = MS_ADDR_W,
    parameter int MEM_IDX_W = MS_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 st_en,
    input  logic [ADDR_W-1:0]    st_addr,
    input  logic [DATA_W-1:0]    st_data,
    input  logic                 ld_en,
    input  logic [MEM_IDX_W-1:0] ld_idx,
    input  logic [DATA_W-1:0]    rd_data,
    output logic                 drain,
    output logic [ADDR_W-1:0]    drain_addr,
    output logic [DATA_W-1:0]    drain_data,
    output logic [DATA_W-1:0]    ld_data
);
    logic              vld;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              hit;

    assign drain      = vld && !ld_en;
    assign drain_addr = addr_q;
    assign drain_data = data_q;

    // Memory only decodes the low index bits, so match on those.
    assign hit     = vld && (ld_idx == addr_q[MEM_IDX_W-1:0]);
    assign ld_data = hit ? data_q : rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (st_en) begin
            vld    <= 1'b1;
            addr_q <= st_addr;
            data_q <= st_data;
        end else if (drain) begin
            vld    <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage, sole master of the data memory port.
// Define MEM_STORE_BUF_EN to decouple stores through a one-entry buffer.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = MS_DATA_W,
    parameter int ADDR_W     = MS_ADDR_W,
    parameter int MEM_IDX_W  = MS_IDX_W,
    parameter int REG_ADDR_W = MS_RD_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_load,
    input  logic                  in_store,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_regwrite,
    mem_access_stage_if.master    mem,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_regwrite
);
    acc_t              acc;
    logic              acc_any;
    logic              ld_acc;
    logic              st_acc;
    logic [DATA_W-1:0] ld_data;

    assign in_ready = !out_valid || out_ready;
    assign acc_any  = in_valid && in_ready;
    assign acc      = acc_decode(in_load, in_store, acc_any);
    assign ld_acc   = (acc == ACC_LOAD);
    assign st_acc   = (acc == ACC_STORE);

`ifdef MEM_STORE_BUF_EN
    logic              drain;
    logic [ADDR_W-1:0] drain_addr;
    logic [DATA_W-1:0] drain_data;

    mem_store_buf #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_IDX_W (MEM_IDX_W)
    ) u_sbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_en      (st_acc),
        .st_addr    (in_addr),
        .st_data    (in_wdata),
        .ld_en      (ld_acc),
        .ld_idx     (in_addr[MEM_IDX_W-1:0]),
        .rd_data    (mem.read_data),
        .drain      (drain),
        .drain_addr (drain_addr),
        .drain_data (drain_data),
        .ld_data    (ld_data)
    );

    // Accepted load owns the port; otherwise the buffer may drain.
    assign mem.read_mem   = ld_acc;
    assign mem.write_mem  = drain;
    assign mem.rw_address = ld_acc ? in_addr
                          : (drain ? drain_addr : '0);
    assign mem.write_data = drain ? drain_data : '0;
`else
    assign mem.read_mem   = ld_acc;
    assign mem.write_mem  = st_acc;
    assign mem.rw_address = (ld_acc || st_acc) ? in_addr : '0;
    assign mem.write_data = st_acc ? in_wdata : '0;
    assign ld_data        = mem.read_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_rd       <= '0;
            out_regwrite <= 1'b0;
        end else if (acc_any) begin
            out_valid    <= 1'b1;
            out_data     <= ld_acc ? ld_data : in_alu_result;
            out_rd       <= in_rd;
            out_regwrite <= in_regwrite && !st_acc;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for the MEM stage.
// Works with and without MEM_STORE_BUF_EN.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_load = 1'b0;
    logic        in_store = 1'b0;
    logic [15:0] in_addr = '0;
    logic [15:0] in_wdata = '0;
    logic [15:0] in_alu_result = '0;
    logic [2:0]  in_rd = '0;
    logic        in_regwrite = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [2:0]  out_rd;
    logic        out_regwrite;

    always #5 clk = ~clk;

    mem_access_stage_if mif();

    mem_access_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_load       (in_load),
        .in_store      (in_store),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_alu_result (in_alu_result),
        .in_rd         (in_rd),
        .in_regwrite   (in_regwrite),
        .mem           (mif),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_rd        (out_rd),
        .out_regwrite  (out_regwrite)
    );

    // Data memory: 16 words, low four address bits decoded.
    logic [15:0] mem  [16];
    logic [15:0] arch [16];
    logic        mem_init = 1'b1;

    assign mif.read_data = mem[mif.rw_address[3:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= arch[i];
        end else if (mif.write_mem) begin
            mem[mif.rw_address[3:0]] <= mif.write_data;
        end
    end

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  rd;
        logic        rw;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   wr_cnt = 0;
    logic rnd_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_regwrite", 32'(out_regwrite), 32'd0);
        chk("rst_read_mem", 32'(mif.read_mem), 32'd0);
        chk("rst_write_mem", 32'(mif.write_mem), 32'd0);
        chk("rst_rw_address", 32'(mif.rw_address), 32'd0);
        chk("rst_write_data", 32'(mif.write_data), 32'd0);
    endtask

    // Port monitor and scoreboard pop, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !mem_init) begin
            chk("port_excl", 32'(mif.read_mem & mif.write_mem), 32'd0);
            if (!mif.read_mem && !mif.write_mem)
                chk("port_idle", {mif.rw_address, mif.write_data}, 32'd0);
            if (mif.write_mem) wr_cnt++;
            if (in_valid && in_ready && in_load) begin
                chk("ld_strobe", 32'(mif.read_mem), 32'd1);
                chk("ld_addr", 32'(mif.rw_address), 32'(in_addr));
            end
`ifndef MEM_STORE_BUF_EN
            if (in_valid && in_ready && in_store && !in_load) begin
                chk("st_strobe", 32'(mif.write_mem), 32'd1);
                chk("st_addr", 32'(mif.rw_address), 32'(in_addr));
                chk("st_data", 32'(mif.write_data), 32'(in_wdata));
            end
`endif
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_empty", 32'(sbq.size()), 32'd1);
                end else begin
                    e = sbq.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_rd", 32'(out_rd), 32'(e.rd));
                    chk("out_regwrite", 32'(out_regwrite), 32'(e.rw));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ld, input logic st,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] alu, input logic [2:0] rd,
                        input logic rw);
        exp_t e;
        int   n;
        in_valid      = 1'b1;
        in_load       = ld;
        in_store      = st;
        in_addr       = a;
        in_wdata      = wd;
        in_alu_result = alu;
        in_rd         = rd;
        in_regwrite   = rw;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.rd = rd;
            e.rw = rw && !(st && !ld);
            e.d  = ld ? arch[a[3:0]] : alu;
            sbq.push_back(e);
            if (st && !ld) arch[a[3:0]] = wd;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_load  = 1'b0;
        in_store = 1'b0;
    endtask

    initial begin
        int          w0;
        logic [15:0] old3;
        for (int i = 0; i < 16; i++) arch[i] = 16'($urandom);
        arch[7] = 16'hBEEF;
        #2;
        chk_reset_state();
        idle(3);
        mem_init = 1'b0;
        rst_n = 1'b1;
        idle(2);

        send(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 3'd5, 1'b1);
        send(1'b1, 1'b0, 16'h0007, 16'h0000, 16'h0000, 3'd2, 1'b1);

        // Store then immediate load to the same decoded index.
        send(1'b0, 1'b1, 16'h0012, 16'hA5A5, 16'h0042, 3'd1, 1'b1);
        send(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 3'd4, 1'b1);
        idle(3);
        chk("fwd_drain_mem2", 32'(mem[2]), 32'h0000_A5A5);

        w0 = wr_cnt;
        send(1'b0, 1'b1, 16'h0001, 16'h1111, 16'h0011, 3'd1, 1'b1);
        send(1'b0, 1'b1, 16'h0002, 16'h2222, 16'h0022, 3'd2, 1'b1);
        idle(3);
        chk("b2b_wr_count", 32'(wr_cnt - w0), 32'd2);
        chk("b2b_mem1", 32'(mem[1]), 32'h0000_1111);
        chk("b2b_mem2", 32'(mem[2]), 32'h0000_2222);

        send(1'b1, 1'b1, 16'h0005, 16'hDEAD, 16'h0000, 3'd3, 1'b1);
        idle(3);
        chk("ldst_mem5", 32'(mem[5]), 32'(arch[5]));

        // Back-pressure: hold a load while WB stalls.
        out_ready = 1'b0;
        send(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h7777, 3'd6, 1'b1);
        in_valid = 1'b1;
        in_load  = 1'b1;
        in_addr  = 16'h0007;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_read_mem", 32'(mif.read_mem), 32'd0);
            chk("bp_write_mem", 32'(mif.write_mem), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'h0000_7777);
            chk("bp_out_rd", 32'(out_rd), 32'd6);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1'b1, 1'b0, 16'h0007, 16'h0000, 16'h0000, 3'd7, 1'b1);

        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    int k;
                    k = $urandom_range(0, 9);
                    send(k < 4, (k >= 3) && (k < 7), 16'($urandom),
                         16'($urandom), 16'($urandom), 3'($urandom),
                         1'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(5);
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], arch[i]);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        // Reset right after a store is accepted.
        old3 = arch[3];
        send(1'b0, 1'b1, 16'h0003, 16'h5A5A, 16'h0000, 3'd1, 1'b1);
`ifdef MEM_STORE_BUF_EN
        arch[3] = old3;
`endif
        rst_n = 1'b0;
        w0 = wr_cnt;
        sbq.delete();
        @(negedge clk);
        chk_reset_state();
        idle(2);
        rst_n = 1'b1;
        idle(4);
        chk("rst_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("rst_mem3", 32'(mem[3]), 32'(arch[3]));
        chk("rst_out_valid_after", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM stage of the 16-bit pipeline; sits between the EX/MEM handshake and the WB stage and is the only master of the data memory port (`read_mem`, `write_mem`, `rw_address`, `write_data`, `read_data`). It issues loads and stores to the memory, selects load data or ALU result, and registers the result into the MEM/WB pipeline register under a valid/ready handshake. An optional one-entry store buffer decouples stores from the shared single memory port and forwards buffered data to matching loads.

## Interface
- `DATA_W`, 16, data width
- `ADDR_W`, 16, address width
- `MEM_IDX_W`, 4, memory index bits actually decoded (address match width)
- `REG_ADDR_W`, 3, destination register index width
- `clk` in 1 — single clock, all state on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `in_valid` in 1 — EX/MEM holds a valid instruction
- `in_ready` out 1 — stage accepts this cycle
- `in_load` / `in_store` in 1 — access type
- `in_addr` in ADDR_W — effective address
- `in_wdata` in DATA_W — store data
- `in_alu_result` in DATA_W — non-load result
- `in_rd` in REG_ADDR_W; `in_regwrite` in 1 — destination info
- `read_mem` out 1; `write_mem` out 1; `rw_address` out ADDR_W; `write_data` out DATA_W — memory port
- `read_data` in DATA_W — combinational memory read data
- `out_valid` out 1; `out_ready` in 1 — WB handshake
- `out_data` out DATA_W; `out_rd` out REG_ADDR_W; `out_regwrite` out 1

## Operation
- Accept = `in_valid && in_ready`; `in_ready = !out_valid || out_ready` (one-entry MEM/WB register).
- Load accept: `read_mem=1`, `rw_address=in_addr`; captured `out_data = read_data`, or buffer data on forward hit.
- Non-load accept: `out_data = in_alu_result`. Store: `out_regwrite` forced 0.
- `in_load && in_store`: load wins, store ignored.
- `out_rd`, `out_regwrite`, `out_data` register on accept; `out_valid` set on accept, cleared on `out_ready` with no accept.
- Memory writes are level-sensitive: `write_mem` high one cycle only; `rw_address`/`write_data` stable for that whole cycle.
- Port arbitration per cycle: accepted load > buffer drain > idle. `read_mem` and `write_mem` never both 1.
- `read_mem=0` / `write_mem=0` whenever not used; address/data outputs then 0.

## Timing
- Reset: `out_valid=0`, `out_data=0`, `out_rd=0`, `out_regwrite=0`, buffer empty, `read_mem=write_mem=0`, `rw_address=write_data=0`.
- Load/ALU latency: result on `out_*` the cycle after accept.
- Back-pressure: `out_valid && !out_ready` → `in_ready=0`, registers hold, no memory access issued for inputs.
- Reset mid-operation: buffered store discarded; no write issued.

## Configuration
- `MEM_STORE_BUF_EN` defined: store accept writes `{in_addr,in_wdata}` into buffer, no port use. Buffer drains (`write_mem=1` from buffer regs) in any cycle with no load accept; buffer clears at that edge. Store accept while buffer full: old entry drains same cycle (port free since no load), new entry captured. Load hit = buffer valid and `in_addr[MEM_IDX_W-1:0]` equals buffered index → `out_data` = buffered data; memory read still issued, result discarded.
- Undefined: store accept drives `write_mem=1`, `rw_address=in_addr`, `write_data=in_wdata` combinationally that cycle; no forwarding logic.

## Structure
- Package `mem_stage_pkg`: width constants, access-type enum (`ACC_NONE/ACC_LOAD/ACC_STORE`).
- Sub-module `mem_store_buf`: entry regs, valid, drain request, index compare/forward mux; instantiated only under the macro.

## Test plan
- Reset asserted mid-stream with store buffered at addr 0x0003 → all outputs 0, no `write_mem` pulse after reset; mem[3] unchanged.
- ALU op `in_alu_result=0x1234`, `in_rd=5`, `in_regwrite=1` → next cycle `out_valid=1`, `out_data=0x1234`, `out_rd=5`.
- Load addr 0x0007, mem[7]=0xBEEF → `read_mem=1` accept cycle, `out_data=0xBEEF` next cycle.
- Buffer on: store 0xA5A5 to 0x0012, then load 0x0002 immediately → forward hit (index 2), `out_data=0xA5A5`; drain on first load-free cycle writes mem[2]=0xA5A5.
- Buffer on: back-to-back stores to 0x1, 0x2 → first drains during second's accept; both memory locations correct, `write_mem` one cycle each.
- `out_ready=0` for 3 cycles with `out_valid=1` → `in_ready=0`, no memory strobes, `out_*` stable; release → next instruction accepted.
